maze_row_loader: RTL and testbench
==================================

# maze_row_loader

Upstream loader for the 1-bit-wide WIDTH×HEIGHT bit memory. It accepts one WIDTH-bit row word per valid/ready handshake and serializes each word into WIDTH single-bit write cycles on the memory's write port. It sweeps y = 0..HEIGHT-1 and pulses `done` when the whole array is written. It sits between the host/testbench stimulus source and the bit-memory write port (`wr`, `addr_x`, `addr_y`, `data_in`).

## Interface
- `WIDTH`, 16, number of x positions; also the row word width
- `HEIGHT`, 16, number of rows (y positions)
- `ADDR_W`, 4, x address width; must satisfy 2^ADDR_W ≥ WIDTH
- `ADDR_H`, 4, y address width; must satisfy 2^ADDR_H ≥ HEIGHT

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin a full-array load; sampled only in IDLE
- `row_valid`  in  1  `row_data` holds a valid row word
- `row_data`  in  WIDTH  row word; bit x goes to address (x, current y)
- `row_ready`  out  1  loader can accept a row word this cycle
- `mem_wr`  out  1  write strobe to the bit memory
- `mem_addr_x`  out  ADDR_W  x address of the current write
- `mem_addr_y`  out  ADDR_H  y address of the current write
- `mem_data`  out  1  bit to write
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last bit is written

## Operation
- States: IDLE, WAIT_ROW, WRITE, DONE.
- IDLE: `row_ready`=0, `mem_wr`=0. If `start`=1, clear y to 0 and go to WAIT_ROW.
- WAIT_ROW: `row_ready`=1. On `row_valid`&`row_ready`, latch `row_data` into the shift register, clear x to 0 and go to WRITE. With no handshake, stay in WAIT_ROW indefinitely.
- WRITE: `mem_wr`=1, `mem_addr_x`=x, `mem_addr_y`=y, `mem_data`=shift[0]. Each cycle, shift right by one and increment x.
  - When x = WIDTH-1 and y = HEIGHT-1, go to DONE.
  - When x = WIDTH-1 and y < HEIGHT-1, increment y and go to WAIT_ROW.
  - `row_ready`=0 throughout WRITE; `row_valid` is ignored.
- DONE: `done`=1 and `mem_wr`=0 for exactly one cycle, then go to IDLE.
- `start` is ignored outside IDLE. A `start` held high through DONE is honoured on the first IDLE cycle, which begins a new load.
- Counters x and y never exceed WIDTH-1 / HEIGHT-1; there is no wrap past the array.
- When `mem_wr`=0, `mem_addr_x`, `mem_addr_y` and `mem_data` hold their last values; these are don't-care to the memory.
- All outputs decode from registered state, counters and the shift register only. There is no combinational path from any input to any output.

## Timing
- Reset: at the first edge with `rst`=1, the state goes to IDLE and the x, y and shift registers clear. `rst` takes priority over all other inputs.
- Reset values of outputs: `row_ready`=0, `mem_wr`=0, `mem_addr_x`=0, `mem_addr_y`=0, `mem_data`=0, `busy`=0, `done`=0.
- Reset asserted mid-load aborts the load. `mem_wr` is 0 from the cycle after the reset edge. Bits already written stay in the memory; the loader does not clear them.
- Cycle numbering: cycle 0 is the IDLE cycle in which `start`=1 is sampled.
- Row r handshake occurs no earlier than cycle 1+(WIDTH+1)·r.
- Row r bits are written in the WIDTH consecutive cycles after its handshake, in x order 0..WIDTH-1. Each write commits at the end of its cycle.
- `row_ready` re-asserts in the cycle immediately after the last write of a row. Minimum row period is WIDTH+1 cycles.
- With `row_valid` held high, the default 16×16 load has its last write in cycle 272, `done`=1 in cycle 273, and IDLE in cycle 274.

## Test plan
- Back-to-back load, default parameters, `row_valid` always 1, row r = 16'h0001<<r:
  - `done` pulses in cycle 273 only.
  - Exactly 256 `mem_wr` cycles occur.
  - The only 1 bits written are at (x=r, y=r).
- Stalled source: `row_valid` dropped for 5 cycles before row 3.
  - `row_ready` stays 1 and `mem_wr` stays 0 during the stall.
  - `done` is delayed by exactly 5 cycles, to cycle 278.
- Bit order: single row word 16'hA5C3 at y=0.
  - Written bits in x order 0..15 are 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
- Reset mid-load: `rst`=1 during the WRITE of row 7, x=9.
  - Next cycle: state IDLE, all outputs at reset values, no further writes.
  - A fresh `start` restarts from (0,0).
- `start` pulsed during WAIT_ROW/WRITE and `row_valid` asserted during WRITE: both are ignored, and the write sequence and `done` timing are unchanged.
- `start` held high continuously: a second load begins in cycle 274, with `row_ready`=1 in cycle 275.

Source files
------------

// File: rtl/maze_row_loader.sv
// ============================================================================
// Module   : maze_row_loader
// Summary  : Serializes WIDTH-bit row words into single-bit writes sweeping a
//            WIDTH x HEIGHT bit memory, row by row.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module maze_row_loader #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int ADDR_W = 4,
    parameter int ADDR_H = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              row_valid,
    input  logic [WIDTH-1:0]  row_data,
    output logic              row_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr_x,
    output logic [ADDR_H-1:0] mem_addr_y,
    output logic              mem_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_H-1:0] Y_LAST = ADDR_H'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ROW = 2'd1,
        S_WRITE    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  x_q, x_d;
    logic [ADDR_H-1:0]  y_q, y_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    // Copies of the last write so the address/data outputs stay put between rows
    logic [ADDR_W-1:0]  hold_x_q, hold_x_d;
    logic [ADDR_H-1:0]  hold_y_q, hold_y_d;
    logic               hold_bit_q, hold_bit_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            shift_q    <= '0;
            hold_x_q   <= '0;
            hold_y_q   <= '0;
            hold_bit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            shift_q    <= shift_d;
            hold_x_q   <= hold_x_d;
            hold_y_q   <= hold_y_d;
            hold_bit_q <= hold_bit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        shift_d    = shift_q;
        hold_x_d   = hold_x_q;
        hold_y_d   = hold_y_q;
        hold_bit_d = hold_bit_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    y_d     = '0;
                    state_d = S_WAIT_ROW;
                end
            end
            S_WAIT_ROW: begin
                if (row_valid) begin
                    shift_d = row_data;
                    x_d     = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                hold_x_d   = x_q;
                hold_y_d   = y_q;
                hold_bit_d = shift_q[0];
                shift_d    = shift_q >> 1;
                if (x_q == X_LAST) begin
                    if (y_q == Y_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        y_d     = y_q + ADDR_H'(1);
                        state_d = S_WAIT_ROW;
                    end
                end else begin
                    x_d = x_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        row_ready  = (state_q == S_WAIT_ROW);
        mem_wr     = (state_q == S_WRITE);
        mem_addr_x = mem_wr ? x_q : hold_x_q;
        mem_addr_y = mem_wr ? y_q : hold_y_q;
        mem_data   = mem_wr ? shift_q[0] : hold_bit_q;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_maze_row_loader.sv
// ============================================================================
// Module   : tb_maze_row_loader
// Summary  : Scoreboard bench for maze_row_loader with directed load scenarios.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_maze_row_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        row_valid;
    logic [15:0] row_data;
    logic        row_ready;
    logic        mem_wr;
    logic [3:0]  mem_addr_x;
    logic [3:0]  mem_addr_y;
    logic        mem_data;
    logic        busy;
    logic        done;

    maze_row_loader #(
        .WIDTH (16),
        .HEIGHT(16),
        .ADDR_W(4),
        .ADDR_H(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_valid (row_valid),
        .row_data  (row_data),
        .row_ready (row_ready),
        .mem_wr    (mem_wr),
        .mem_addr_x(mem_addr_x),
        .mem_addr_y(mem_addr_y),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    int          rel;
    int          wr_cnt;
    int          ones_cnt;
    int          done_cnt;
    int          done_rel;
    int          hs_idx;
    int          w0;
    int          d0;
    int          o0;
    logic [15:0] cap;
    logic [15:0] rows [16];
    logic [8:0]  exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_row_ready"}, 32'(row_ready), 32'd0);
        chk({pfx, "_mem_wr"},    32'(mem_wr),    32'd0);
        chk({pfx, "_addr_x"},    32'(mem_addr_x), 32'd0);
        chk({pfx, "_addr_y"},    32'(mem_addr_y), 32'd0);
        chk({pfx, "_mem_data"},  32'(mem_data),  32'd0);
        chk({pfx, "_busy"},      32'(busy),      32'd0);
        chk({pfx, "_done"},      32'(done),      32'd0);
    endtask

    // Sample at the falling edge, model the handshake, advance to just after the next rising edge.
    task automatic step();
        logic [8:0] e;
        @(negedge clk);
        if (mem_wr) begin
            wr_cnt++;
            if (mem_data) ones_cnt++;
            if (mem_addr_y == 4'd0) cap[mem_addr_x] = mem_data;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("write", {23'd0, mem_addr_x, mem_addr_y, mem_data}, {23'd0, e});
            end
        end
        if (done) begin
            done_cnt++;
            done_rel = rel;
        end
        if (rst) begin
            exp_q.delete();
            hs_idx = 0;
        end else if (row_valid && row_ready) begin
            for (int x = 0; x < 16; x++)
                exp_q.push_back({4'(x), 4'(hs_idx), rows[hs_idx][x]});
            hs_idx++;
        end else if (start && !busy) begin
            hs_idx = 0;
        end
        @(posedge clk);
        #1;
        rel++;
        row_data = (hs_idx < 16) ? rows[hs_idx] : 16'h0000;
    endtask

    // mode 0: plain, 1: stall before row 3, 2: start noise while busy, 3: start held
    task automatic run_load(input int mode, input int stop_rel);
        w0 = wr_cnt;
        d0 = done_cnt;
        o0 = ones_cnt;
        rel = 0;
        start = 1'b1;
        row_valid = 1'b1;
        while (rel < stop_rel) begin
            if (rel > 0) begin
                if (mode == 2)
                    start = (rel < 273) ? 1'($urandom_range(0, 1)) : 1'b0;
                else
                    start = (mode == 3);
            end
            row_valid = !(mode == 1 && rel >= 52 && rel <= 56);
            if (mode == 1 && rel >= 52 && rel <= 56) begin
                chk("stall_row_ready", 32'(row_ready), 32'd1);
                chk("stall_mem_wr", 32'(mem_wr), 32'd0);
            end
            step();
        end
    endtask

    initial begin
        total = 0; bad = 0; rel = 0;
        wr_cnt = 0; ones_cnt = 0; done_cnt = 0; done_rel = -1; hs_idx = 0;
        cap = '0;
        rst = 1'b1;
        start = 1'b0;
        row_valid = 1'b0;
        row_data = '0;
        for (int r = 0; r < 16; r++) rows[r] = '0;
        repeat (3) step();
        chk_idle("reset");
        rst = 1'b0;
        step();

        // Bit order on row 0, then abort during row 7 at x=9
        rows[0] = 16'hA5C3;
        for (int r = 1; r < 16; r++) rows[r] = 16'($urandom);
        run_load(0, 130);
        chk("abort_point_x", 32'(mem_addr_x), 32'd9);
        chk("abort_point_y", 32'(mem_addr_y), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("abort");
        repeat (10) step();
        chk("abort_write_count", 32'(wr_cnt - w0), 32'd122);
        chk("bit_order", 32'(cap), 32'h0000A5C3);

        // Fresh back-to-back load with a diagonal pattern
        for (int r = 0; r < 16; r++) rows[r] = 16'h0001 << r;
        run_load(0, 276);
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd1);
        chk("b2b_done_cycle", 32'(done_rel), 32'd273);
        chk("b2b_write_count", 32'(wr_cnt - w0), 32'd256);
        chk("b2b_ones", 32'(ones_cnt - o0), 32'd16);
        chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("b2b_idle", 32'(busy), 32'd0);

        // Source stall before row 3
        run_load(1, 281);
        chk("stall_done_count", 32'(done_cnt - d0), 32'd1);
        chk("stall_done_cycle", 32'(done_rel), 32'd278);
        chk("stall_write_count", 32'(wr_cnt - w0), 32'd256);

        // start toggled while busy, random data
        for (int r = 0; r < 16; r++) rows[r] = 16'($urandom);
        run_load(2, 276);
        chk("noise_done_count", 32'(done_cnt - d0), 32'd1);
        chk("noise_done_cycle", 32'(done_rel), 32'd273);
        chk("noise_write_count", 32'(wr_cnt - w0), 32'd256);
        chk("noise_sb_empty", 32'(exp_q.size()), 32'd0);

        // start held high: reload begins straight after DONE
        run_load(3, 274);
        chk("held_done_cycle", 32'(done_rel), 32'd273);
        chk("held_c274_busy", 32'(busy), 32'd0);
        chk("held_c274_row_ready", 32'(row_ready), 32'd0);
        step();
        chk("held_c275_row_ready", 32'(row_ready), 32'd1);
        chk("held_c275_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        start = 1'b0;
        step();
        rst = 1'b0;
        chk_idle("held_abort");
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
